instruction_fetch_unit: RTL and testbench

//  Fetch stage of the MIPS pipeline. Owns the PC, drives the combinational Instruction_memory

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/instruction_fetch_unit_ifid_register.sv | 53 +++++
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word type, reset/bubble constants, FSM encoding.
package instruction_fetch_unit_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t       DEF_RESET_PC  = 32'h0000_0000;
  localparam word_t       DEF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam int unsigned DEF_MEM_WORDS = 30;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls in, imem read port, IF/ID outputs and status.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic  stall;
  logic  ifid_flush;
  logic  branch_taken;
  word_t branch_target;
  logic  jump;
  word_t jump_target;
  word_t imem_addr;
  word_t imem_instr;
  word_t ifid_instr;
  word_t ifid_pc_plus4;
  logic  ifid_valid;
  logic  halted;
  word_t fetch_count;

  modport master (
    input  stall, ifid_flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, halted, fetch_count
  );

  modport slave (
    output stall, ifid_flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, halted, fetch_count
  );

endinterface

// File: rtl/instruction_fetch_unit_ifid_register.sv
// IF/ID pipeline register: flush inserts a bubble (pc_plus4 kept), stall holds every field.
module ifid_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter word_t NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  flush,
  input  word_t instr_in,
  input  word_t pc_plus4_in,
  input  logic  valid_in,
  output word_t instr,
  output word_t pc_plus4,
  output logic  valid
);

  word_t instr_q, instr_d;
  word_t pc_plus4_q, pc_plus4_d;
  logic  valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = valid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, next-PC selection, RUN/HALT control and fetch counter.
// IF/ID capture is one edge after the PC is presented to the combinational imem.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter word_t       RESET_PC  = DEF_RESET_PC,
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
  parameter word_t       NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  io
);

  localparam word_t MEM_LIMIT = word_t'(MEM_WORDS * 4);

  word_t        pc_q, pc_d;
  word_t        fetch_count_q, fetch_count_d;
  fetch_state_e state_q, state_d;

  logic  redirect;
  logic  in_range;
  logic  stall_eff;
  logic  ifid_squash;
  logic  wr_valid;
  word_t target;
  word_t pc_plus4;
  word_t ifid_instr_in;

  assign redirect    = io.jump | io.branch_taken;
  assign target      = word_align(io.jump ? io.jump_target : io.branch_target);
  assign in_range    = (pc_q < MEM_LIMIT);
  assign pc_plus4    = pc_q + 32'd4;
  // HALT ignores the hazard unit entirely; only a redirect or reset gets us out.
  assign stall_eff   = io.stall & (state_q == FETCH_RUN);
  assign ifid_squash = redirect | io.ifid_flush;
  assign wr_valid    = ~ifid_squash & ~stall_eff & in_range;
  assign ifid_instr_in = in_range ? io.imem_instr : NOP_INSTR;

  always_comb begin
    pc_d = pc_plus4;
    if (redirect) begin
      pc_d = target;
    end else if (stall_eff || (state_q == FETCH_HALT) || !in_range) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, wr_valid};
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN:  if (!in_range && !redirect && !io.stall) state_d = FETCH_HALT;
      FETCH_HALT: if (redirect) state_d = FETCH_RUN;
      default:    state_d = FETCH_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    io.halted = (state_q == FETCH_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifid_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall_eff),
    .flush       (ifid_squash),
    .instr_in    (ifid_instr_in),
    .pc_plus4_in (pc_plus4),
    .valid_in    (in_range),
    .instr       (io.ifid_instr),
    .pc_plus4    (io.ifid_pc_plus4),
    .valid       (io.ifid_valid)
  );

  assign io.imem_addr   = pc_q;
  assign io.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a 30-word combinational imem image.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instruction_fetch_unit_if io ();

  instruction_fetch_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:29];

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    if (a < 32'd120) return mem[a[6:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign io.imem_instr = imem_rd(io.imem_addr);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    exp_t        e;
    logic        redir, inr, hold_ifid;
    logic [31:0] tgt;
    io.stall = st; io.ifid_flush = fl; io.branch_taken = br; io.branch_target = bt;
    io.jump = j; io.jump_target = jt;

    redir     = j | br;
    tgt       = j ? jt : bt;
    tgt[1:0]  = 2'b00;
    inr       = m_pc < 32'd120;
    hold_ifid = st && !m_halt;
    if (redir || fl) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (!hold_ifid) begin
      m_pc4 = m_pc + 32'd4;
      if (inr) begin
        m_instr = mem[m_pc[6:2]]; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end else begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
    end
    if (m_halt) m_halt = !redir;
    else        m_halt = !inr && !redir && !st;
    if (redir)                          m_pc = tgt;
    else if (!(st || !inr || m_halt))   m_pc = m_pc + 32'd4;

    e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.cnt = m_cnt;
    e.valid = m_valid; e.halted = m_halt;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("imem_addr", io.imem_addr, e.addr);
    chk("ifid_instr", io.ifid_instr, e.instr);
    chk("ifid_pc_plus4", io.ifid_pc_plus4, e.pc4);
    chk("fetch_count", io.fetch_count, e.cnt);
    chk("ifid_valid", {31'd0, io.ifid_valid}, {31'd0, e.valid});
    chk("halted", {31'd0, io.halted}, {31'd0, e.halted});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_addr"}, io.imem_addr, 32'h0);
    chk({tag, "_instr"}, io.ifid_instr, 32'h0);
    chk({tag, "_pc4"}, io.ifid_pc_plus4, 32'h0);
    chk({tag, "_cnt"}, io.fetch_count, 32'h0);
    chk({tag, "_valid"}, {31'd0, io.ifid_valid}, 32'h0);
    chk({tag, "_halted"}, {31'd0, io.halted}, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 30; i++) mem[i] = 32'h2400_0000 | i;
    mem[0]  = 32'h2008_0020;
    mem[1]  = 32'h2009_0027;
    mem[2]  = 32'h0109_8024;
    mem[18] = 32'h2008_0000;

    io.stall = 1'b0; io.ifid_flush = 1'b0; io.branch_taken = 1'b0;
    io.branch_target = 32'h0; io.jump = 1'b0; io.jump_target = 32'h0;
    reset = 1'b1;
    model_reset();
    #12;
    chk_cleared("reset");
    reset = 1'b0;

    // straight-line fetch
    idle(1);
    chk("t1_i0", io.ifid_instr, 32'h2008_0020);
    chk("t1_p0", io.ifid_pc_plus4, 32'd4);
    idle(1);
    chk("t1_i1", io.ifid_instr, 32'h2009_0027);
    chk("t1_p1", io.ifid_pc_plus4, 32'd8);
    idle(1);
    chk("t1_i2", io.ifid_instr, 32'h0109_8024);
    chk("t1_p2", io.ifid_pc_plus4, 32'd12);
    chk("t1_cnt", io.fetch_count, 32'd3);

    // stall holds PC and IF/ID
    idle(1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("t2_addr", io.imem_addr, 32'h10);
      chk("t2_instr", io.ifid_instr, 32'h2400_0003);
      chk("t2_cnt", io.fetch_count, 32'd4);
    end

    // taken branch at 0x24
    idle(5);
    chk("t3_pc", io.imem_addr, 32'h24);
    step(1'b0, 1'b0, 1'b1, 32'h48, 1'b0, 32'h0);
    chk("t3_addr", io.imem_addr, 32'h48);
    chk("t3_bubble", {31'd0, io.ifid_valid}, 32'h0);
    idle(1);
    chk("t3_instr", io.ifid_instr, 32'h2008_0000);
    chk("t3_valid", {31'd0, io.ifid_valid}, 32'h1);

    // jump together with stall: redirect wins
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h38);
    chk("t4_addr", io.imem_addr, 32'h38);
    chk("t4_squash", {31'd0, io.ifid_valid}, 32'h0);
    idle(2);

    // external flush, flush with stall, jump beating branch
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h22);
    chk("jprio_addr", io.imem_addr, 32'h20);
    idle(2);

    // jump out of range (misaligned target), halt, then recover
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7F);
    chk("t5_addr", io.imem_addr, 32'h7C);
    chk("t5_nohalt", {31'd0, io.halted}, 32'h0);
    idle(1);
    chk("t5_halted", {31'd0, io.halted}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(2);
    chk("t5_hold", io.imem_addr, 32'h7C);
    chk("t5_valid", {31'd0, io.ifid_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("t5_resume", {31'd0, io.halted}, 32'h0);
    idle(1);
    chk("t5_mem0", io.ifid_instr, 32'h2008_0020);

    // run off the end of the image naturally, then branch back
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h70);
    idle(4);
    chk("end_addr", io.imem_addr, 32'h78);
    chk("end_halted", {31'd0, io.halted}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 32'h0);
    idle(2);

    // asynchronous reset mid-run
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    idle(12);
    chk("t6_pc", io.imem_addr, 32'h30);
    chk("t6_cnt", io.fetch_count, 32'd12);
    #2 reset = 1'b1;
    #1;
    chk_cleared("t6");
    reset = 1'b0;
    model_reset();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
